// File: rtl/otter_pipe_pkg.sv
// Shared types and helpers for the OTTER pipeline hazard logic.
// Defines the scoreboard entry record, the x0 constant and the forward-select width.
package otter_pipe_pkg;

    localparam int SB_AW = 5;

    typedef struct packed {
        logic             v;
        logic [SB_AW-1:0] rd;
        logic             wr;
        logic             ld;
    } sb_entry_t;

    localparam logic [SB_AW-1:0] REG_X0 = '0;

    function automatic int fwd_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/otter_sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
// Ports: CLK, RST (sync, active-low), inc (count enable), count (current value).
module otter_sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/otter_hazard_scoreboard.sv
// Hazard control beside decode: scoreboard of in-flight writers, stall/flush, forward selects.
// Ports: CLK/RST, id_* decode fields, ex_flush; stall, flush_ifid, fwd_sel_a/b, stall_cnt, flush_cnt.
module otter_hazard_scoreboard
    import otter_pipe_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int REG_AW = 5,
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 32
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      id_valid,
    input  logic [REG_AW-1:0]         id_rs1,
    input  logic [REG_AW-1:0]         id_rs2,
    input  logic                      id_use_rs1,
    input  logic                      id_use_rs2,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_regwrite,
    input  logic                      id_is_load,
    input  logic                      ex_flush,
    output logic                      stall,
    output logic                      flush_ifid,
    output logic [fwd_w(DEPTH)-1:0]   fwd_sel_a,
    output logic [fwd_w(DEPTH)-1:0]   fwd_sel_b,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          flush_cnt
);

    localparam int FW = fwd_w(DEPTH);
    // Entries that still hazard without forwarding: everything but WB.
    localparam logic [DEPTH-1:0] PRE_WB = {DEPTH{1'b1}} >> 1;

    sb_entry_t        sb_q [DEPTH];
    sb_entry_t        sb_d [DEPTH];
    logic [FW-1:0]    sel_a_q;
    logic [FW-1:0]    sel_a_d;
    logic [FW-1:0]    sel_b_q;
    logic [FW-1:0]    sel_b_d;
    logic [DEPTH-1:0] m_a;
    logic [DEPTH-1:0] m_b;
    logic             hz;
    logic             enter;

    function automatic logic hit(
        input sb_entry_t         e,
        input logic [REG_AW-1:0] rs,
        input logic              en
    );
        return en && e.v && e.wr &&
               (e.rd == SB_AW'(rs)) &&
               (SB_AW'(rs) != REG_X0);
    endfunction

    always_comb begin
        m_a = '0;
        m_b = '0;
        for (int k = 0; k < DEPTH; k++) begin
            m_a[k] = hit(sb_q[k], id_rs1, id_use_rs1);
            m_b[k] = hit(sb_q[k], id_rs2, id_use_rs2);
        end
    end

    // With forwarding only a load still in EX is too late; without it
    // anything short of WB (write-before-read regfile) must wait.
    always_comb begin
        hz = 1'b0;
        if (FWD_EN) begin
            hz = (m_a[0] | m_b[0]) & sb_q[0].ld;
        end else begin
            hz = |((m_a | m_b) & PRE_WB);
        end
    end

    assign stall      = id_valid & hz & ~ex_flush;
    assign flush_ifid = ex_flush;
    assign enter      = id_valid & ~stall & ~ex_flush;

    // Youngest producer wins: scan oldest to youngest, last hit sticks.
    always_comb begin
        sel_a_d = '0;
        sel_b_d = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (m_a[k]) sel_a_d = FW'(k + 1);
            if (m_b[k]) sel_b_d = FW'(k + 1);
        end
        if (!enter || !FWD_EN) begin
            sel_a_d = '0;
            sel_b_d = '0;
        end
    end

    always_comb begin
        sb_d[0] = '0;
        if (enter) begin
            sb_d[0].v  = 1'b1;
            sb_d[0].rd = SB_AW'(id_rd);
            sb_d[0].wr = id_regwrite;
            sb_d[0].ld = id_is_load;
        end
        for (int k = 1; k < DEPTH; k++) begin
            sb_d[k] = sb_q[k-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int k = 0; k < DEPTH; k++) begin
                sb_q[k] <= '0;
            end
            sel_a_q <= '0;
            sel_b_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                sb_q[k] <= sb_d[k];
            end
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
        end
    end

    assign fwd_sel_a = sel_a_q;
    assign fwd_sel_b = sel_b_q;

    otter_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (stall),
        .count (stall_cnt)
    );

    otter_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (ex_flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_otter_hazard_scoreboard.sv
// Bench for otter_hazard_scoreboard: forwarding instance (A) and stall-only instance (B).
// Directed vector table, hand sequences, then random stimulus against a reference model.
module tb_otter_hazard_scoreboard;

    logic       CLK = 1'b0;
    logic       RST;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] id_rd;
    logic       id_regwrite;
    logic       id_is_load;
    logic       ex_flush;

    logic        stall_a, flush_a;
    logic [1:0]  fsa_a, fsb_a;
    logic [31:0] sc_a, fc_a;
    logic        stall_b, flush_b;
    logic [1:0]  fsa_b, fsb_b;
    logic [2:0]  sc_b, fc_b;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    otter_hazard_scoreboard #(
        .DEPTH(3), .REG_AW(5), .FWD_EN(1'b1), .CNT_W(32)
    ) dut_a (
        .CLK(CLK), .RST(RST), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_is_load(id_is_load), .ex_flush(ex_flush),
        .stall(stall_a), .flush_ifid(flush_a),
        .fwd_sel_a(fsa_a), .fwd_sel_b(fsb_a),
        .stall_cnt(sc_a), .flush_cnt(fc_a)
    );

    otter_hazard_scoreboard #(
        .DEPTH(3), .REG_AW(5), .FWD_EN(1'b0), .CNT_W(3)
    ) dut_b (
        .CLK(CLK), .RST(RST), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_is_load(id_is_load), .ex_flush(ex_flush),
        .stall(stall_b), .flush_ifid(flush_b),
        .fwd_sel_a(fsa_b), .fwd_sel_b(fsb_b),
        .stall_cnt(sc_b), .flush_cnt(fc_b)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       wr;
        bit       ld;
    } ins_t;

    ins_t pa [3];
    ins_t pb [3];
    int unsigned m_fa, m_fb;
    longint unsigned m_sc_a, m_fc_a, m_sc_b, m_fc_b;

    function automatic bit prod(ins_t p, bit [4:0] rs, bit en);
        return en && rs != 0 && p.v && p.wr && p.rd == rs;
    endfunction

    // A producer at position k feeds the consumer in time only once it
    // has reached its ready position: ALU 0 / load 1 with forwarding,
    // WB (2) without.
    function automatic bit m_stall(bit fwd);
        ins_t p;
        int   ready;
        bit   s;
        s = 0;
        if (!id_valid || ex_flush) return 0;
        for (int k = 0; k < 3; k++) begin
            p = fwd ? pa[k] : pb[k];
            ready = fwd ? (p.ld ? 1 : 0) : 2;
            if ((prod(p, id_rs1, id_use_rs1) ||
                 prod(p, id_rs2, id_use_rs2)) && k < ready)
                s = 1;
        end
        return s;
    endfunction

    function automatic int unsigned nearest(bit [4:0] rs, bit en);
        for (int k = 0; k < 3; k++)
            if (prod(pa[k], rs, en)) return k + 1;
        return 0;
    endfunction

    task automatic m_clear();
        for (int k = 0; k < 3; k++) begin
            pa[k] = '{default: 0};
            pb[k] = '{default: 0};
        end
        m_fa = 0; m_fb = 0;
        m_sc_a = 0; m_fc_a = 0; m_sc_b = 0; m_fc_b = 0;
    endtask

    task automatic m_clock();
        bit   sa, sb, ea, eb;
        ins_t cur;
        sa = m_stall(1'b1);
        sb = m_stall(1'b0);
        if (!RST) begin
            m_clear();
        end else begin
            ea = id_valid && !sa && !ex_flush;
            eb = id_valid && !sb && !ex_flush;
            m_fa = ea ? nearest(id_rs1, id_use_rs1) : 0;
            m_fb = ea ? nearest(id_rs2, id_use_rs2) : 0;
            cur = '{v: 1, rd: id_rd, wr: id_regwrite, ld: id_is_load};
            for (int k = 2; k > 0; k--) begin
                pa[k] = pa[k-1];
                pb[k] = pb[k-1];
            end
            pa[0] = ea ? cur : '{default: 0};
            pb[0] = eb ? cur : '{default: 0};
            if (sa && m_sc_a < 64'hFFFF_FFFF) m_sc_a++;
            if (ex_flush && m_fc_a < 64'hFFFF_FFFF) m_fc_a++;
            if (sb && m_sc_b < 7) m_sc_b++;
            if (ex_flush && m_fc_b < 7) m_fc_b++;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model();
        chk("stall_A", 64'(stall_a), 64'(m_stall(1'b1)));
        chk("stall_B", 64'(stall_b), 64'(m_stall(1'b0)));
        chk("flush_A", 64'(flush_a), 64'(ex_flush));
        chk("flush_B", 64'(flush_b), 64'(ex_flush));
        chk("fsel_a_A", 64'(fsa_a), 64'(m_fa));
        chk("fsel_b_A", 64'(fsb_a), 64'(m_fb));
        chk("fsel_a_B", 64'(fsa_b), 64'd0);
        chk("fsel_b_B", 64'(fsb_b), 64'd0);
        chk("scnt_A", 64'(sc_a), m_sc_a);
        chk("fcnt_A", 64'(fc_a), m_fc_a);
        chk("scnt_B", 64'(sc_b), m_sc_b);
        chk("fcnt_B", 64'(fc_b), m_fc_b);
    endtask

    typedef struct {
        bit       rst, v;
        bit [4:0] rs1, rs2;
        bit       u1, u2;
        bit [4:0] rd;
        bit       wr, ld, fl;
        bit       e_sta, e_stb;
        bit [1:0] e_fa, e_fb;
        int       e_sc, e_fc;
    } vec_t;

    function automatic vec_t mk(
        bit rst, bit v, bit [4:0] rs1, bit [4:0] rs2, bit u1, bit u2,
        bit [4:0] rd, bit wr, bit ld, bit fl,
        bit sta, bit stb, bit [1:0] fa, bit [1:0] fb, int sc, int fc);
        vec_t t;
        t.rst = rst; t.v = v; t.rs1 = rs1; t.rs2 = rs2;
        t.u1 = u1; t.u2 = u2; t.rd = rd; t.wr = wr; t.ld = ld;
        t.fl = fl; t.e_sta = sta; t.e_stb = stb;
        t.e_fa = fa; t.e_fb = fb; t.e_sc = sc; t.e_fc = fc;
        return t;
    endfunction

    task automatic apply(vec_t t);
        RST = t.rst; id_valid = t.v;
        id_rs1 = t.rs1; id_rs2 = t.rs2;
        id_use_rs1 = t.u1; id_use_rs2 = t.u2;
        id_rd = t.rd; id_regwrite = t.wr; id_is_load = t.ld;
        ex_flush = t.fl;
    endtask

    task automatic tick();
        @(posedge CLK);
        m_clock();
        #1;
    endtask

    // apply one cycle of stimulus and check everything against the model
    task automatic cyc(vec_t t);
        apply(t);
        @(negedge CLK);
        check_model();
    endtask

    vec_t tbl[$];
    vec_t nop;

    initial begin
        nop = mk(1,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0);
        // rst v rs1 rs2 u1 u2 rd wr ld fl | stA stB fa fb sc fc
        // back-to-back ALU
        tbl.push_back(mk(1,1, 1,2,1,1, 5,1,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(1,1, 5,1,1,1, 6,1,0,0, 0,1,0,0,0,0));
        tbl.push_back(mk(1,0, 0,0,0,0, 0,0,0,0, 0,0,1,0,0,0));
        repeat (3) tbl.push_back(nop);
        // load-use
        tbl.push_back(mk(1,1, 1,0,1,0, 7,1,1,0, 0,0,0,0,0,0));
        tbl.push_back(mk(1,1, 7,7,1,1, 8,1,0,0, 1,1,0,0,0,0));
        tbl.push_back(mk(1,1, 7,7,1,1, 8,1,0,0, 0,1,0,0,1,0));
        tbl.push_back(mk(1,0, 0,0,0,0, 0,0,0,0, 0,0,2,2,1,0));
        tbl.push_back(mk(1,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,1,0));
        tbl.push_back(mk(1,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,1,0));
        // x0 destination
        tbl.push_back(mk(1,1, 1,0,1,0, 0,1,0,0, 0,0,0,0,1,0));
        tbl.push_back(mk(1,1, 0,0,1,1, 9,1,0,0, 0,0,0,0,1,0));
        tbl.push_back(mk(1,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,1,0));
        // flush beats load-use stall
        tbl.push_back(mk(1,1, 1,0,1,0, 7,1,1,0, 0,0,0,0,1,0));
        tbl.push_back(mk(1,1, 7,0,1,1, 8,1,0,1, 0,0,0,0,1,0));
        tbl.push_back(mk(1,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,1,1));
        // fill with load writers to x3, reset mid-stall
        repeat (3) tbl.push_back(mk(1,1, 0,0,0,0, 3,1,1,0, 0,0,0,0,1,1));
        tbl.push_back(mk(0,1, 3,3,1,1, 4,1,0,0, 1,1,0,0,1,1));
        tbl.push_back(mk(1,1, 3,3,1,1, 4,1,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(1,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0));

        m_clear();
        apply(nop);
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        foreach (tbl[i]) begin
            apply(tbl[i]);
            @(negedge CLK);
            check_model();
            chk($sformatf("tbl%0d_stallA", i), 64'(stall_a), 64'(tbl[i].e_sta));
            chk($sformatf("tbl%0d_stallB", i), 64'(stall_b), 64'(tbl[i].e_stb));
            chk($sformatf("tbl%0d_fselA_a", i), 64'(fsa_a), 64'(tbl[i].e_fa));
            chk($sformatf("tbl%0d_fselA_b", i), 64'(fsb_a), 64'(tbl[i].e_fb));
            chk($sformatf("tbl%0d_scntA", i), 64'(sc_a), 64'(tbl[i].e_sc));
            chk($sformatf("tbl%0d_fcntA", i), 64'(fc_a), 64'(tbl[i].e_fc));
            tick();
        end

        // stall-only mode: producer in EX then MEM stalls, WB releases
        repeat (2) begin cyc(nop); tick(); end
        cyc(mk(1,1, 1,0,1,0, 5,1,0,0, 0,0,0,0,0,0));
        chk("nofwd_p1_stall", 64'(stall_b), 64'd0);
        tick();
        cyc(mk(1,1, 5,2,1,1, 6,1,0,0, 0,0,0,0,0,0));
        chk("nofwd_ex_stall", 64'(stall_b), 64'd1);
        tick();
        cyc(mk(1,1, 5,2,1,1, 6,1,0,0, 0,0,0,0,0,0));
        chk("nofwd_mem_stall", 64'(stall_b), 64'd1);
        tick();
        cyc(mk(1,1, 5,2,1,1, 6,1,0,0, 0,0,0,0,0,0));
        chk("nofwd_wb_release", 64'(stall_b), 64'd0);
        tick();
        cyc(nop);
        chk("nofwd_stall_cnt", 64'(sc_b), 64'd2);
        tick();

        // flush counter saturation on the 3-bit instance
        repeat (9) begin
            cyc(mk(1,0, 0,0,0,0, 0,0,0,1, 0,0,0,0,0,0));
            tick();
        end
        cyc(nop);
        chk("sat_fcnt_B", 64'(fc_b), 64'd7);
        chk("sat_fcnt_A", 64'(fc_a), 64'd9);
        tick();

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            vec_t r;
            r = nop;
            r.rst = ($urandom_range(39) != 0);
            r.v   = ($urandom_range(3) != 0);
            r.rs1 = 5'($urandom_range(3));
            r.rs2 = 5'($urandom_range(3));
            r.u1  = 1'($urandom);
            r.u2  = 1'($urandom);
            r.rd  = 5'($urandom_range(3));
            r.wr  = ($urandom_range(3) != 0);
            r.ld  = ($urandom_range(2) == 0);
            r.fl  = ($urandom_range(7) == 0);
            cyc(r);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
